// File: rtl/struct_update_arbiter.sv
// Round-robin arbiter owning one shared x/y/z struct register with a 3-cycle clear.
// Define STRUCT_UPDATE_ARBITER_ERR_EN to enable the sticky invalid-slot err flag.
module struct_update_arbiter #(
  parameter int N_REQ = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [2*N_REQ-1:0]    req_slot,
  input  logic [3*N_REQ-1:0]    req_mask,
  input  logic [24*N_REQ-1:0]   req_data,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [71:0]           state_o,
  output logic [CNT_W-1:0]      commit_count,
  output logic                  err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } inner_t;

  typedef struct packed {
    inner_t x;
    inner_t y;
    inner_t z;
  } outer_t;

  typedef enum logic [1:0] {
    IDLE,
    CLR_X,
    CLR_Y,
    CLR_Z
  } st_e;

  st_e             st_q, st_d;
  outer_t          os_q, os_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win;
  logic            hit;
  logic            arb_en;
  logic            hs;
  logic [1:0]      w_slot;
  logic [2:0]      w_mask;
  inner_t          w_data;

  function automatic inner_t merge(
    input inner_t   o,
    input logic [2:0] m,
    input inner_t   d
  );
    inner_t r;
    r   = o;
    if (m[2]) r.a = d.a;
    if (m[1]) r.b = d.b;
    if (m[0]) r.c = d.c;
    return r;
  endfunction

  // first valid requester at or after the pointer, wrapping
  always_comb begin
    int idx;
    hit = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        win = PW'(idx);
      end
    end
  end

  assign arb_en = reset_n && (st_q == IDLE) && !clear_req;
  assign hs     = arb_en && hit;
  assign w_slot = req_slot[2*int'(win) +: 2];
  assign w_mask = req_mask[3*int'(win) +: 3];
  assign w_data = req_data[24*int'(win) +: 24];

  always_comb begin
    req_ready = '0;
    if (hs) req_ready = N_REQ'(1) << win;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      if (int'(win) == N_REQ - 1) ptr_d = '0;
      else                        ptr_d = win + PW'(1);
    end
  end

  always_comb begin
    st_d = st_q;
    busy = (st_q != IDLE);
    unique case (st_q)
      IDLE:  if (clear_req) st_d = CLR_X;
      CLR_X: st_d = CLR_Y;
      CLR_Y: st_d = CLR_Z;
      CLR_Z: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    os_d  = os_q;
    cnt_d = cnt_q;
    unique case (st_q)
      CLR_X: os_d.x = '0;
      CLR_Y: os_d.y = '0;
      CLR_Z: os_d.z = '0;
      default: begin
        if (hs && w_slot != 2'd3) begin
          unique case (w_slot)
            2'd0:    os_d.x = merge(os_q.x, w_mask, w_data);
            2'd1:    os_d.y = merge(os_q.y, w_mask, w_data);
            default: os_d.z = merge(os_q.z, w_mask, w_data);
          endcase
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= IDLE;
      os_q  <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
    end else begin
      st_q  <= st_d;
      os_q  <= os_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign state_o      = os_q;
  assign commit_count = cnt_q;

`ifdef STRUCT_UPDATE_ARBITER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (hs && w_slot == 2'd3) err_d = 1'b1;
    if (st_q == CLR_Z)        err_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_struct_update_arbiter.sv
// Bench for struct_update_arbiter: byte-array model checked every cycle
// plus directed scenarios with literal expectations.
module tb_struct_update_arbiter;

  localparam int N = 3;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [2*N-1:0]  req_slot = '0;
  logic [3*N-1:0]  req_mask = '0;
  logic [24*N-1:0] req_data = '0;
  logic         clear_req = 1'b0;
  logic         busy;
  logic [71:0]  state_o;
  logic [15:0]  commit_count;
  logic         err;

  int errors = 0;
  int checks = 0;

  struct_update_arbiter #(.N_REQ(N), .CNT_W(16)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_slot(req_slot),
    .req_mask(req_mask),
    .req_data(req_data),
    .clear_req(clear_req),
    .busy(busy),
    .state_o(state_o),
    .commit_count(commit_count),
    .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: m[slot][field], field 0=a 1=b 2=c
  logic [7:0] m [3][3];
  int mcnt;
  int mptr;
  int mphase;
  bit merr;

  function automatic logic [71:0] mpack();
    logic [71:0] p;
    p = '0;
    for (int s = 0; s < 3; s++)
      for (int f = 0; f < 3; f++)
        p[71-24*s-8*f -: 8] = m[s][f];
    return p;
  endfunction

  always @(negedge clock) begin
    logic [N-1:0] er;
    int w;
    int idx;
    int s;
    if (!reset_n) begin
      for (int a = 0; a < 3; a++)
        for (int f = 0; f < 3; f++) m[a][f] = 8'h00;
      mcnt = 0; mptr = 0; mphase = 0; merr = 1'b0;
    end
    er = '0;
    w  = -1;
    if (reset_n && mphase == 0 && !clear_req)
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    if (w >= 0) er[w] = 1'b1;
    chk("ready", 72'(req_ready), 72'(er));
    chk("busy", 72'(busy), 72'(mphase != 0));
    chk("state", state_o, mpack());
    chk("count", 72'(commit_count), 72'(mcnt));
`ifdef STRUCT_UPDATE_ARBITER_ERR_EN
    chk("err", 72'(err), 72'(merr));
`else
    chk("err", 72'(err), 72'(0));
`endif
    if (reset_n) begin
      if (mphase != 0) begin
        for (int f = 0; f < 3; f++) m[mphase-1][f] = 8'h00;
        if (mphase == 3) begin
          mphase = 0;
          merr = 1'b0;
        end else mphase++;
      end else if (clear_req) begin
        mphase = 1;
      end else if (w >= 0) begin
        s = int'(req_slot[2*w +: 2]);
        if (s == 3) merr = 1'b1;
        else begin
          for (int f = 0; f < 3; f++)
            if (req_mask[3*w + (2-f)])
              m[s][f] = req_data[24*w + 8*(2-f) +: 8];
          if (mcnt < 65535) mcnt++;
        end
        mptr = (w + 1) % N;
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] s,
                         input logic [2:0] mk, input logic [23:0] d);
    req_valid[i] = 1'b1;
    req_slot[2*i +: 2] = s;
    req_mask[3*i +: 3] = mk;
    req_data[24*i +: 24] = d;
  endtask

  task automatic do_req(input int i, input logic [1:0] s,
                        input logic [2:0] mk, input logic [23:0] d);
    bit got;
    got = 1'b0;
    set_req(i, s, mk, d);
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clock);
      got = req_ready[i];
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: requester %0d got no ready, required 1", i);
    end
    @(posedge clock); #1;
    req_valid[i] = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // reset state after release
    repeat (2) @(negedge clock);
    chk("rst_state", state_o, 72'h0);
    chk("rst_count", 72'(commit_count), 72'h0);
    chk("rst_busy", 72'(busy), 72'h0);
    chk("rst_ready", 72'(req_ready), 72'h0);
    @(posedge clock); #1;

    // full write to y
    do_req(0, 2'd1, 3'b111, 24'h040506);
    chk("y_write", state_o, {24'h0, 24'h040506, 24'h0});
    chk("y_count", 72'(commit_count), 72'd1);

    // masked write into preloaded z
    do_req(0, 2'd2, 3'b111, 24'h070809);
    do_req(2, 2'd2, 3'b010, 24'hAABBCC);
    chk("z_masked", state_o, {24'h0, 24'h040506, 24'h07BB09});
    chk("z_count", 72'(commit_count), 72'd3);

    // three requesters held valid: strict rotation
    set_req(0, 2'd0, 3'b111, 24'h111111);
    set_req(1, 2'd1, 3'b111, 24'h222222);
    set_req(2, 2'd2, 3'b111, 24'h333333);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("rr_grant", 72'(req_ready), 72'(3'b001 << (k % 3)));
      @(posedge clock); #1;
    end
    req_valid = '0;
    chk("rr_count", 72'(commit_count), 72'd9);
    chk("rr_state", state_o, {24'h111111, 24'h222222, 24'h333333});

    // preload all ones, then clear racing a request
    do_req(0, 2'd0, 3'b111, 24'hFFFFFF);
    do_req(1, 2'd1, 3'b111, 24'hFFFFFF);
    do_req(2, 2'd2, 3'b111, 24'hFFFFFF);
    clear_req = 1'b1;
    set_req(1, 2'd0, 3'b111, 24'h123456);
    @(negedge clock);
    chk("clr_ready0", 72'(req_ready), 72'h0);
    @(posedge clock); #1;
    clear_req = 1'b0;
    @(negedge clock);
    chk("clr_x_busy", 72'(busy), 72'd1);
    chk("clr_x_state", state_o, {72{1'b1}});
    @(negedge clock);
    chk("clr_y_state", state_o, {24'h0, {48{1'b1}}});
    @(negedge clock);
    chk("clr_z_state", state_o, {48'h0, {24{1'b1}}});
    chk("clr_z_ready", 72'(req_ready), 72'h0);
    @(negedge clock);
    chk("clr_done", state_o, 72'h0);
    chk("clr_busy0", 72'(busy), 72'h0);
    chk("clr_regrant", 72'(req_ready), 72'(3'b010));
    @(posedge clock); #1;
    req_valid = '0;
    chk("post_clr_x", state_o, {24'h123456, 48'h0});
    chk("post_clr_cnt", 72'(commit_count), 72'd13);

    // invalid slot: dropped, not counted
    do_req(0, 2'd3, 3'b111, 24'hABCDEF);
    chk("bad_state", state_o, {24'h123456, 48'h0});
    chk("bad_count", 72'(commit_count), 72'd13);
`ifdef STRUCT_UPDATE_ARBITER_ERR_EN
    chk("bad_err", 72'(err), 72'd1);
`else
    chk("bad_err", 72'(err), 72'd0);
`endif
    clear_req = 1'b1;
    @(posedge clock); #1;
    clear_req = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("err_cleared", 72'(err), 72'd0);
    chk("clr2_state", state_o, 72'h0);

    // async reset mid-cycle with a live request
    do_req(2, 2'd1, 3'b111, 24'h555555);
    set_req(0, 2'd0, 3'b111, 24'h000001);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("arst_state", state_o, 72'h0);
    chk("arst_count", 72'(commit_count), 72'h0);
    chk("arst_ready", 72'(req_ready), 72'h0);
    chk("arst_busy", 72'(busy), 72'h0);
    @(posedge clock); #1;
    req_valid = '0;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("arst_hold", state_o, 72'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench ran past time limit");
    $fatal(1);
  end

endmodule

// File: doc/struct_update_arbiter.md
Name: struct_update_arbiter

Overview:
- Owns one shared OuterStruct register: three InnerStruct slots x/y/z, each holding byte fields a/b/c.
- Arbitrates masked field-write requests from N_REQ requesters, round-robin, at most one commit per cycle.
- Runs a 3-cycle slot-clear sequence on command.
- Sits between producer blocks and any consumer of the packed OuterStruct state.

Parameters:
N_REQ, 3, number of requesters (2..8)
CNT_W, 16, width of commit counter

Ports:
clock  input  1  global clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester grant; handshake = valid & ready
req_slot  input  2*N_REQ  target slot per requester: 0=x, 1=y, 2=z, 3=invalid
req_mask  input  3*N_REQ  field enables per requester: bit2=a, bit1=b, bit0=c
req_data  input  24*N_REQ  InnerStruct payload per requester: a[23:16], b[15:8], c[7:0]
clear_req  input  1  start slot-clear sequence
busy  output  1  clear sequence in progress
state_o  output  72  OuterStruct register: x[71:48], y[47:24], z[23:0]
commit_count  output  CNT_W  number of committed writes, saturating
err  output  1  sticky invalid-slot flag (only with optional feature)

Behaviour:
- One clock (clock); reset is asynchronous and active-low (reset_n).
- Reset (reset_n low, async): state_o=0, commit_count=0, rr pointer=0, FSM=IDLE, err=0.
  - req_ready is all 0 while reset_n is low.
  - Outputs hold these values until the first rising clock edge after release.
- FSM states: IDLE, CLR_X, CLR_Y, CLR_Z.
  - IDLE -> CLR_X when clear_req=1 is sampled.
  - CLR_X -> CLR_Y -> CLR_Z -> IDLE unconditionally, one cycle each.
  - busy=1 in every state except IDLE.
- Clear:
  - At the edge leaving CLR_X, x<=0; leaving CLR_Y, y<=0; leaving CLR_Z, z<=0.
  - clear_req is ignored outside IDLE.
  - In IDLE, clear_req has priority over requests: req_ready=0 for that cycle.
- Arbitration (IDLE only, clear_req=0):
  - req_ready is combinational from req_valid and the rr pointer.
  - Winner w = first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod N_REQ.
  - req_ready is one-hot on w; zero if no request is valid.
  - On handshake, ptr <= (w+1) mod N_REQ. With no handshake, ptr holds.
  - In non-IDLE states req_ready=0.
- Commit (at the handshake edge, slot 0..2):
  - Each masked byte of the selected slot takes the corresponding req_data byte; unmasked bytes hold.
  - Mask 0 still counts as a commit.
  - commit_count += 1, saturating at all-ones (no wrap).
- Invalid slot (slot=3): handshake completes and the pointer advances, but there is no state change and no count.
- Write visibility: state_o reflects a write at the cycle after the handshake (1-cycle latency).
- Requester behaviour: requesters hold valid and payload until ready. The arbiter never grants more than one requester per cycle.
- Reset mid-clear: the FSM returns to IDLE and all state zeroes immediately; no partial-sweep remnants.

Optional Feature:
- Macro STRUCT_UPDATE_ARBITER_ERR_EN.
- Defined:
  - err is a live output: set on any handshake with slot=3, sticky until reset.
  - A clear sequence also clears err, at the CLR_Z edge.
- Undefined:
  - err is tied to 0 and no error register is synthesized.
  - Invalid-slot behaviour is otherwise identical (request dropped, not counted).

Test Plan:
- Reset release, no requests -> state_o=0, commit_count=0, busy=0, req_ready=0; assert reset_n low mid-cycle -> outputs zero without a clock edge.
- Req0 only: slot=1, mask=3'b111, data=24'h040506 -> next cycle y=24'h040506, commit_count=1; x and z remain 0.
- Masked write: z preloaded to 24'h070809; req slot=2, mask=3'b010, data=24'hAABBCC -> z=24'h07BB09.
- All three valid continuously, distinct slots -> grants 0,1,2,0,1,2 on consecutive cycles; commit_count=6 after 6 cycles; exactly one req_ready bit high per cycle.
- clear_req together with req1 valid, state preloaded to all 8'hFF bytes -> req_ready=0 that cycle; busy=1 for 3 cycles; x, y, z zero in order; req1 granted the first IDLE cycle after.
- ERR_EN defined: req slot=3 -> err=1, state and count unchanged; after a clear sequence, err=0. ERR_EN undefined -> err stays 0.
